// File: rtl/lamp_pkg.sv
// lamp_pkg: shared lamp encodings, timer state type and dwell selection
//   LIGHT_RED/GREEN/YELLOW  one-hot lamp codes on a [0:2] vector
//   timer_state_t           IDLE, LOAD, COUNT, FIRE, WAIT
//   light_ok / dwell_sel    legality check and per-phase dwell lookup
package lamp_pkg;
    typedef logic [0:2] light_t;
    localparam light_t LIGHT_RED    = 3'b100;
    localparam light_t LIGHT_GREEN  = 3'b010;
    localparam light_t LIGHT_YELLOW = 3'b001;
    typedef enum logic [2:0] {IDLE, LOAD, COUNT, FIRE, WAIT} timer_state_t;
    function automatic logic light_ok(input light_t l);
        return l == LIGHT_RED || l == LIGHT_GREEN || l == LIGHT_YELLOW;
    endfunction
    // illegal codes and zero dwells both fall back to one second
    function automatic int dwell_sel(input light_t l, input int r, input int g, input int y);
        int d;
        d = l == LIGHT_RED ? r : l == LIGHT_GREEN ? g : l == LIGHT_YELLOW ? y : 1;
        return d < 1 ? 1 : d;
    endfunction
endpackage

// File: rtl/lamp_phase_timer_if.sv
// lamp_phase_timer_if: bundle between the phase timer and the lamp side
//   master (timer): in enable, light, ped_req*; out advance, sec_tick, remaining, fault
//   slave  (lamp/controller): the mirror image
//   * ped_req exists only when LAMP_PED_REQ_EN is defined
interface lamp_phase_timer_if #(parameter int SEC_W = 8);
    import lamp_pkg::*;
    logic             enable;
    light_t           light;
`ifdef LAMP_PED_REQ_EN
    logic             ped_req;
`endif
    logic             advance;
    logic             sec_tick;
    logic [SEC_W-1:0] remaining;
    logic             fault;
    modport master (
        input  enable, light,
`ifdef LAMP_PED_REQ_EN
        input  ped_req,
`endif
        output advance, sec_tick, remaining, fault
    );
    modport slave (
        output enable, light,
`ifdef LAMP_PED_REQ_EN
        output ped_req,
`endif
        input  advance, sec_tick, remaining, fault
    );
endinterface

// File: rtl/lamp_phase_timer_sec_prescaler.sv
// sec_prescaler: divides fast_clk into a one-cycle tick every PRESCALE cycles
//   fast_clk, rst_n  clock, async active-low reset
//   clr              restart the count at zero
//   run              count enable; the count is held at zero while low
//   tick             high on the last cycle of each PRESCALE period
module sec_prescaler #(
    parameter int CNT_W    = 25,
    parameter int PRESCALE = 25_000_000
) (
    input  logic fast_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);
    logic [CNT_W-1:0] presc;
    assign tick = run && presc == CNT_W'(PRESCALE - 1);
    always_ff @(posedge fast_clk or negedge rst_n)
        if (!rst_n) presc <= '0;
        else        presc <= (clr || !run || tick) ? '0 : presc + 1'b1;
endmodule

// File: rtl/lamp_phase_timer.sv
// lamp_phase_timer: per-phase dwell countdown that paces the traffic-lamp FSM
//   fast_clk, rst_n  clock, async active-low reset
//   bus (master)     enable/light[/ped_req] in; advance/sec_tick/remaining/fault out
//   Define LAMP_PED_REQ_EN to let ped_req shorten a GREEN phase to PED_MIN_SEC.
module lamp_phase_timer
    import lamp_pkg::*;
#(
    parameter int PRESCALE    = 25_000_000,
    parameter int CNT_W       = 25,
    parameter int SEC_W       = 8,
    parameter int RED_SEC     = 10,
    parameter int GREEN_SEC   = 8,
    parameter int YELLOW_SEC  = 2,
    parameter int WAIT_MAX    = 4,
    parameter int PED_MIN_SEC = 3
) (
    input logic             fast_clk,
    input logic             rst_n,
    lamp_phase_timer_if.master bus
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    timer_state_t     state, state_nx;
    light_t           cap;
    logic [WW-1:0]    wait_cnt;
    logic [SEC_W-1:0] rem_nx;
    logic             fault_nx, tick, ped_hit;
`ifdef LAMP_PED_REQ_EN
    assign ped_hit = state == COUNT && bus.enable && bus.ped_req &&
                     bus.light == LIGHT_GREEN && bus.remaining > SEC_W'(PED_MIN_SEC);
`else
    assign ped_hit = 1'b0;
`endif
    sec_prescaler #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_presc (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .clr      (ped_hit),
        .run      (state == COUNT),
        .tick     (tick)
    );
    assign bus.sec_tick = tick;
    always_comb begin
        state_nx = state;
        rem_nx   = bus.remaining;
        fault_nx = bus.fault;
        if (!bus.enable) state_nx = IDLE;
        else case (state)
            IDLE:  state_nx = LOAD;
            LOAD: begin
                rem_nx   = SEC_W'(dwell_sel(bus.light, RED_SEC, GREEN_SEC, YELLOW_SEC));
                fault_nx = bus.fault | !light_ok(bus.light);
                state_nx = COUNT;
            end
            // a pedestrian request overrides a coincident second tick
            COUNT: begin
                rem_nx   = ped_hit ? SEC_W'(PED_MIN_SEC) : tick ? bus.remaining - 1'b1 : bus.remaining;
                state_nx = (!ped_hit && tick && bus.remaining == SEC_W'(1)) ? FIRE : COUNT;
            end
            FIRE:  state_nx = WAIT;
            WAIT: begin
                state_nx = (bus.light != cap || wait_cnt == WW'(WAIT_MAX - 1)) ? LOAD : WAIT;
                fault_nx = bus.fault | (bus.light == cap && wait_cnt == WW'(WAIT_MAX - 1));
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge fast_clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            bus.remaining <= '0;
            bus.fault     <= 1'b0;
            bus.advance   <= 1'b0;
            cap           <= '0;
            wait_cnt      <= '0;
        end else begin
            state         <= state_nx;
            bus.remaining <= rem_nx;
            bus.fault     <= fault_nx;
            bus.advance   <= state_nx == FIRE;
            cap           <= state == FIRE ? bus.light : cap;
            wait_cnt      <= state == WAIT ? wait_cnt + 1'b1 : '0;
        end
endmodule

// File: tb/tb_lamp_phase_timer.sv
// tb_lamp_phase_timer: directed self-checking bench for lamp_phase_timer
module tb_lamp_phase_timer;
    import lamp_pkg::*;
    logic fast_clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0, n_fail = 0, n;
    bit   pend = 1'b0, seen;
    int   per[6] = '{11, 7, 15, 11, 7, 15};
    lamp_phase_timer_if #(.SEC_W(8)) bus ();
    lamp_phase_timer #(
        .PRESCALE(4), .CNT_W(3), .SEC_W(8), .RED_SEC(3), .GREEN_SEC(2),
        .YELLOW_SEC(1), .WAIT_MAX(4), .PED_MIN_SEC(1)
    ) dut (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );
    always #5 fast_clk = ~fast_clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic nxt();
        @(posedge fast_clk);
        #1;
    endtask
    function automatic light_t lamp_next(input light_t l);
        return l == LIGHT_RED ? LIGHT_GREEN : l == LIGHT_GREEN ? LIGHT_YELLOW : LIGHT_RED;
    endfunction
    // edges until advance is seen; a pending advance steps the lamp one edge late
    task automatic wait_adv(input int lim, input bit resp, output int cnt);
        cnt = 0;
        do begin
            nxt();
            cnt++;
            if (pend) begin
                if (resp) bus.light = lamp_next(bus.light);
                pend = 1'b0;
            end
        end while (!bus.advance && cnt < lim);
        if (!bus.advance) chk("adv_timeout", 0, 1);
        pend = bus.advance;
    endtask
    task automatic restart(input light_t l);
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.light = l;
        pend = 1'b0;
        nxt();
        rst_n = 1'b1;
        bus.enable = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.enable = 1'b0;
        bus.light = LIGHT_RED;
`ifdef LAMP_PED_REQ_EN
        bus.ped_req = 1'b0;
`endif
        nxt();
        nxt();
        rst_n = 1'b1;
        bus.enable = 1'b1;
        for (int e = 0; e <= 4; e++) nxt();
        chk("mid_rem", int'(bus.remaining), 3);
        chk("mid_tick", int'(bus.sec_tick), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_adv", int'(bus.advance), 0);
        chk("rst_tick", int'(bus.sec_tick), 0);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_fault", int'(bus.fault), 0);
        restart(LIGHT_RED);
        for (int e = 0; e <= 13; e++) begin
            nxt();
            chk($sformatf("t2_adv_e%0d", e), int'(bus.advance), int'(e == 13));
            if (e == 1)  chk("t2_rem3", int'(bus.remaining), 3);
            if (e == 5)  chk("t2_rem2", int'(bus.remaining), 2);
            if (e == 9)  chk("t2_rem1", int'(bus.remaining), 1);
            if (e == 13) chk("t2_rem0", int'(bus.remaining), 0);
            if (e == 3)  chk("t2_tick_lo", int'(bus.sec_tick), 0);
            if (e == 4)  chk("t2_tick_hi", int'(bus.sec_tick), 1);
        end
        pend = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_adv(40, 1'b1, n);
            chk($sformatf("t3_period%0d", i), n, per[i]);
        end
        chk("t3_fault", int'(bus.fault), 0);
        pend = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            nxt();
            if (i == 4) chk("t4_fault_pre", int'(bus.fault), 0);
            if (i == 5) chk("t4_fault_set", int'(bus.fault), 1);
        end
        wait_adv(40, 1'b0, n);
        chk("t4_reload", n, 13);
        wait_adv(40, 1'b1, n);
        chk("t4_recover", n, 11);
        chk("t4_sticky", int'(bus.fault), 1);
        restart(3'b000);
        nxt();
        chk("t5_fault_load", int'(bus.fault), 0);
        nxt();
        chk("t5_fault", int'(bus.fault), 1);
        chk("t5_rem", int'(bus.remaining), 1);
        for (int e = 2; e <= 5; e++) begin
            nxt();
            chk($sformatf("t5_adv_e%0d", e), int'(bus.advance), int'(e == 5));
        end
        restart(LIGHT_RED);
        for (int e = 0; e <= 6; e++) nxt();
        chk("t6_rem_pre", int'(bus.remaining), 2);
        bus.enable = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            nxt();
            seen |= bus.advance;
        end
        chk("t6_no_adv", int'(seen), 0);
        chk("t6_frozen", int'(bus.remaining), 2);
        bus.enable = 1'b1;
        nxt();
        nxt();
        chk("t6_reload", int'(bus.remaining), 3);
        wait_adv(40, 1'b0, n);
        chk("t6_adv", n, 12);
`ifdef LAMP_PED_REQ_EN
        restart(LIGHT_GREEN);
        for (int e = 0; e <= 4; e++) nxt();
        chk("t7_tick", int'(bus.sec_tick), 1);
        chk("t7_rem_pre", int'(bus.remaining), 2);
        bus.ped_req = 1'b1;
        nxt();
        bus.ped_req = 1'b0;
        chk("t7_rem", int'(bus.remaining), 1);
        wait_adv(40, 1'b0, n);
        chk("t7_adv", n, 4);
        restart(LIGHT_GREEN);
        for (int e = 0; e <= 2; e++) nxt();
        chk("t7b_rem_pre", int'(bus.remaining), 2);
        bus.ped_req = 1'b1;
        nxt();
        bus.ped_req = 1'b0;
        chk("t7b_rem", int'(bus.remaining), 1);
        wait_adv(40, 1'b0, n);
        chk("t7b_adv", n, 4);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
